// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for a three-digit seven-segment display with
// per-slot blanking, leading-zero suppression and frame-coherent snapshots.
module seg7_scan_mux #(
   parameter int PRESCALE       = 4,
   parameter int SLOT_TICKS     = 4,
   parameter int BLANK_TICKS    = 1,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0,
   parameter int LZB            = 1
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       en,
   input  logic [6:0] uni,
   input  logic [6:0] dez,
   input  logic [6:0] cen,
   output logic [6:0] seg,
   output logic [2:0] dig,
   output logic       frame_start
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   localparam logic [15:0] PMAX   = 16'(PRESCALE - 1);
   localparam logic [7:0]  TLAST  = 8'(SLOT_TICKS - 1);
   localparam logic [7:0]  TBLANK = 8'(BLANK_TICKS);

   state_t      state, state_nx;
   logic [1:0]  idx, idx_nx;
   logic [15:0] pcnt, pcnt_nx;
   logic [7:0]  tcnt, tcnt_nx;
   logic [6:0]  snap_uni, snap_uni_nx;
   logic [6:0]  snap_dez, snap_dez_nx;
   logic [6:0]  snap_cen, snap_cen_nx;
   logic        fs_nx;
   logic [6:0]  seg_r, seg_nx;
   logic [2:0]  dig_r, dig_nx;
   logic        tick;
   logic        cen_blank, dez_blank;
   logic [6:0]  pat;

   assign tick = (pcnt == PMAX);

   always_comb begin
      state_nx    = state;
      idx_nx      = idx;
      pcnt_nx     = pcnt;
      tcnt_nx     = tcnt;
      snap_uni_nx = snap_uni;
      snap_dez_nx = snap_dez;
      snap_cen_nx = snap_cen;
      fs_nx       = 1'b0;

      if (state == IDLE) begin
         pcnt_nx = 16'd0;
         tcnt_nx = 8'd0;
         idx_nx  = 2'd0;
         if (en) begin
            state_nx    = BLANK;
            snap_uni_nx = uni;
            snap_dez_nx = dez;
            snap_cen_nx = cen;
            fs_nx       = 1'b1;
         end
      end else if (!en) begin
         // Disable wins over a coincident frame boundary: no new frame starts.
         state_nx = IDLE;
         pcnt_nx  = 16'd0;
         tcnt_nx  = 8'd0;
         idx_nx   = 2'd0;
      end else begin
         pcnt_nx = tick ? 16'd0 : pcnt + 16'd1;
         if (tick) begin
            if (tcnt == TLAST) begin
               tcnt_nx  = 8'd0;
               state_nx = BLANK;
               if (idx == 2'd2) begin
                  idx_nx      = 2'd0;
                  snap_uni_nx = uni;
                  snap_dez_nx = dez;
                  snap_cen_nx = cen;
                  fs_nx       = 1'b1;
               end else begin
                  idx_nx = idx + 2'd1;
               end
            end else begin
               tcnt_nx  = tcnt + 8'd1;
               state_nx = (tcnt_nx < TBLANK) ? BLANK : SHOW;
            end
         end
      end
   end

   // Outputs are computed from the next-state values so the registered
   // seg/dig line up with state and idx in the same cycle.
   always_comb begin
      cen_blank = (LZB != 0) && (snap_cen_nx == 7'h3F);
      dez_blank = cen_blank && (snap_dez_nx == 7'h3F);
      case (idx_nx)
         2'd0:    pat = snap_uni_nx;
         2'd1:    pat = dez_blank ? 7'h00 : snap_dez_nx;
         default: pat = cen_blank ? 7'h00 : snap_cen_nx;
      endcase
      seg_nx = 7'h00;
      dig_nx = 3'b000;
      if (state_nx == SHOW) begin
         seg_nx = pat;
         dig_nx = 3'b001 << idx_nx;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state       <= IDLE;
         idx         <= 2'd0;
         pcnt        <= 16'd0;
         tcnt        <= 8'd0;
         snap_uni    <= 7'h00;
         snap_dez    <= 7'h00;
         snap_cen    <= 7'h00;
         frame_start <= 1'b0;
         seg_r       <= 7'h00;
         dig_r       <= 3'b000;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         pcnt        <= pcnt_nx;
         tcnt        <= tcnt_nx;
         snap_uni    <= snap_uni_nx;
         snap_dez    <= snap_dez_nx;
         snap_cen    <= snap_cen_nx;
         frame_start <= fs_nx;
         seg_r       <= seg_nx;
         dig_r       <= dig_nx;
      end
   end

   assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_r : seg_r;
   assign dig = (DIG_ACTIVE_LOW != 0) ? ~dig_r : dig_r;

endmodule
